// File: rtl/memmu_write_arbiter_if.sv
// rtl/memmu_write_arbiter_if.sv - producer and memory-port bundle for memmu_write_arbiter
interface memmu_write_arbiter_if #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int PAYLOAD_W = 64
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]           i_CH_valid;
  logic [NUM_CH-1:0]           o_CH_ready;
  logic [NUM_CH*ADDR_W-1:0]    i_CH_address;
  logic [NUM_CH*PAYLOAD_W-1:0] i_CH_payload;
  logic [NUM_CH-1:0]           i_CH_enable;
  logic                        o_MemMU_writeValid;
  logic                        i_MEM_writeReady;
  logic [ADDR_W-1:0]           o_MemMU_writeAddress;
  logic [PAYLOAD_W-1:0]        o_MemMU_writePayload;
  logic [CH_W-1:0]             o_MemMU_writeChannel;
  logic [NUM_CH-1:0]           o_MemMU_fifoFull;
  logic [31:0]                 o_MemMU_writeCount;

  // slave = the arbiter itself; master = producers plus memory
  modport slave (
    input  i_CH_valid, i_CH_address, i_CH_payload, i_CH_enable, i_MEM_writeReady,
    output o_CH_ready, o_MemMU_writeValid, o_MemMU_writeAddress, o_MemMU_writePayload,
           o_MemMU_writeChannel, o_MemMU_fifoFull, o_MemMU_writeCount
  );

  modport master (
    output i_CH_valid, i_CH_address, i_CH_payload, i_CH_enable, i_MEM_writeReady,
    input  o_CH_ready, o_MemMU_writeValid, o_MemMU_writeAddress, o_MemMU_writePayload,
           o_MemMU_writeChannel, o_MemMU_fifoFull, o_MemMU_writeCount
  );
endinterface

// File: rtl/memmu_write_arbiter.sv
// rtl/memmu_write_arbiter.sv - per-channel write FIFOs arbitrated onto one registered memory write port
module memmu_write_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int PAYLOAD_W  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input logic                  i_SYSTEM_clk,
  input logic                  i_SYSTEM_rst,
  memmu_write_arbiter_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = ADDR_W + PAYLOAD_W;

  logic [BEAT_W-1:0]    fifo_mem [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr   [NUM_CH];
  logic [PTR_W-1:0]     rd_ptr   [NUM_CH];
  logic [CNT_W-1:0]     occ      [NUM_CH];

  logic [NUM_CH-1:0]    full;
  logic [NUM_CH-1:0]    eligible;
  logic [NUM_CH-1:0]    ch_ready;
  logic [NUM_CH-1:0]    push;
  logic [NUM_CH-1:0]    pop;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      grant;
  logic                 grant_valid;
  logic                 out_free;
  logic [BEAT_W-1:0]    head;

  logic                 out_valid;
  logic [ADDR_W-1:0]    out_addr;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CH_W-1:0]      out_ch;
  logic [31:0]          write_count;

  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int step);
    int s;
    s = (int'(base) + step) % NUM_CH;
    return CH_W'(s);
  endfunction

  always_comb begin
    full     = '0;
    eligible = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]     = (occ[k] == CNT_W'(FIFO_DEPTH));
      eligible[k] = (occ[k] != '0) & bus.i_CH_enable[k];
    end
  end

  // Ready comes only from registered occupancy, so a full FIFO refuses a push even while it pops.
  assign ch_ready = ~full & {NUM_CH{i_SYSTEM_rst}};
  assign push     = bus.i_CH_valid & ch_ready;
  assign out_free = ~out_valid | bus.i_MEM_writeReady;

  // Loops run against search order so the last hit written is the winner.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (ARB_MODE == 0) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (eligible[k]) begin
          grant       = CH_W'(k);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_CH; i >= 1; i--) begin
        if (eligible[rr_index(rr_ptr, i)]) begin
          grant       = rr_index(rr_ptr, i);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign pop  = (out_free & grant_valid) ? (NUM_CH'(1) << grant) : '0;
  assign head = fifo_mem[grant][rd_ptr[grant]];

  always_ff @(posedge i_SYSTEM_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) begin
        fifo_mem[k][wr_ptr[k]] <= {bus.i_CH_address[k*ADDR_W +: ADDR_W],
                                   bus.i_CH_payload[k*PAYLOAD_W +: PAYLOAD_W]};
      end
    end
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (!i_SYSTEM_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        occ[k] <= occ[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
    end
  end

  // Address/payload/channel only move on a grant, so they hold through stalls and idle cycles.
  always_ff @(posedge i_SYSTEM_clk) begin
    if (!i_SYSTEM_rst) begin
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_payload <= '0;
      out_ch      <= '0;
      rr_ptr      <= CH_W'(NUM_CH - 1);
      write_count <= '0;
    end else begin
      if (out_valid & bus.i_MEM_writeReady) write_count <= write_count + 32'd1;
      if (out_free) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_addr    <= head[BEAT_W-1 -: ADDR_W];
          out_payload <= head[PAYLOAD_W-1:0];
          out_ch      <= grant;
          rr_ptr      <= grant;
        end
      end
    end
  end

  assign bus.o_CH_ready           = ch_ready;
  assign bus.o_MemMU_fifoFull     = full & {NUM_CH{i_SYSTEM_rst}};
  assign bus.o_MemMU_writeValid   = out_valid;
  assign bus.o_MemMU_writeAddress = out_addr;
  assign bus.o_MemMU_writePayload = out_payload;
  assign bus.o_MemMU_writeChannel = out_ch;
  assign bus.o_MemMU_writeCount   = write_count;
endmodule

// File: tb/tb_memmu_write_arbiter.sv
// tb/tb_memmu_write_arbiter.sv - queue-model scoreboard bench for a fixed-priority and a round-robin arbiter
module tb_memmu_write_arbiter;
  localparam int AW    = 16;
  localparam int PW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]    ch;
    logic [AW-1:0] a;
    logic [PW-1:0] p;
  } ent_t;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    vld  [2];
  logic [2:0]    en   [2];
  logic          mrdy [2];
  logic [AW-1:0] adr  [2][3];
  logic [PW-1:0] pay  [2][3];

  logic [2:0]    o_rdy  [2];
  logic [2:0]    o_full [2];
  logic          o_vld  [2];
  logic [AW-1:0] o_adr  [2];
  logic [PW-1:0] o_pay  [2];
  logic [1:0]    o_ch   [2];
  logic [31:0]   o_cnt  [2];

  memmu_write_arbiter_if #(.NUM_CH(2), .ADDR_W(AW), .PAYLOAD_W(PW)) b0 ();
  memmu_write_arbiter_if #(.NUM_CH(3), .ADDR_W(AW), .PAYLOAD_W(PW)) b1 ();

  memmu_write_arbiter #(.NUM_CH(2), .ADDR_W(AW), .PAYLOAD_W(PW), .FIFO_DEPTH(DEPTH), .ARB_MODE(0))
    dut0 (.i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(b0.slave));
  memmu_write_arbiter #(.NUM_CH(3), .ADDR_W(AW), .PAYLOAD_W(PW), .FIFO_DEPTH(DEPTH), .ARB_MODE(1))
    dut1 (.i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(b1.slave));

  assign b0.i_CH_valid       = vld[0][1:0];
  assign b0.i_CH_enable      = en[0][1:0];
  assign b0.i_MEM_writeReady = mrdy[0];
  assign b0.i_CH_address     = {adr[0][1], adr[0][0]};
  assign b0.i_CH_payload     = {pay[0][1], pay[0][0]};
  assign b1.i_CH_valid       = vld[1];
  assign b1.i_CH_enable      = en[1];
  assign b1.i_MEM_writeReady = mrdy[1];
  assign b1.i_CH_address     = {adr[1][2], adr[1][1], adr[1][0]};
  assign b1.i_CH_payload     = {pay[1][2], pay[1][1], pay[1][0]};

  assign o_rdy[0]  = {1'b0, b0.o_CH_ready};
  assign o_full[0] = {1'b0, b0.o_MemMU_fifoFull};
  assign o_vld[0]  = b0.o_MemMU_writeValid;
  assign o_adr[0]  = b0.o_MemMU_writeAddress;
  assign o_pay[0]  = b0.o_MemMU_writePayload;
  assign o_ch[0]   = {1'b0, b0.o_MemMU_writeChannel};
  assign o_cnt[0]  = b0.o_MemMU_writeCount;
  assign o_rdy[1]  = b1.o_CH_ready;
  assign o_full[1] = b1.o_MemMU_fifoFull;
  assign o_vld[1]  = b1.o_MemMU_writeValid;
  assign o_adr[1]  = b1.o_MemMU_writeAddress;
  assign o_pay[1]  = b1.o_MemMU_writePayload;
  assign o_ch[1]   = b1.o_MemMU_writeChannel;
  assign o_cnt[1]  = b1.o_MemMU_writeCount;

  int checks   = 0;
  int failures = 0;
  bit live     = 0;
  int nch_of  [2] = '{2, 3};
  int mode_of [2] = '{0, 1};

  ent_t        mq    [2][3][$];
  ent_t        exp_q [2][$];
  int          seq1  [$];
  bit          m_vld [2];
  ent_t        m_out [2];
  int          m_ptr [2];
  logic [31:0] m_cnt [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: one queue per channel, one output slot, grant chosen by the arbitration rule.
  task automatic step(input int d);
    int   n;
    int   g;
    bit   found;
    bit   can_push [3];
    ent_t e;
    n = nch_of[d];
    if (!rst) begin
      for (int k = 0; k < 3; k++) mq[d][k].delete();
      exp_q[d].delete();
      m_vld[d] = 0;
      m_out[d] = '0;
      m_cnt[d] = 32'd0;
      m_ptr[d] = n - 1;
      return;
    end
    for (int k = 0; k < n; k++) can_push[k] = (mq[d][k].size() < DEPTH);
    if (m_vld[d] && mrdy[d]) m_cnt[d] = m_cnt[d] + 32'd1;
    if (!m_vld[d] || mrdy[d]) begin
      found = 0;
      g     = 0;
      for (int i = 1; i <= n; i++) begin
        int k;
        k = (mode_of[d] != 0) ? (m_ptr[d] + i) % n : i - 1;
        if (!found && en[d][k] && mq[d][k].size() > 0) begin
          found = 1;
          g     = k;
        end
      end
      if (found) begin
        m_out[d] = mq[d][g].pop_front();
        m_vld[d] = 1;
        m_ptr[d] = g;
        exp_q[d].push_back(m_out[d]);
      end else begin
        m_vld[d] = 0;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (vld[d][k] && can_push[k]) begin
        e.ch = 2'(k);
        e.a  = adr[d][k];
        e.p  = pay[d][k];
        mq[d][k].push_back(e);
      end
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [2:0] er;
      logic [2:0] ef;
      if (live) begin
        er = '0;
        ef = '0;
        for (int k = 0; k < nch_of[d]; k++) begin
          ef[k] = rst && (mq[d][k].size() == DEPTH);
          er[k] = rst && (mq[d][k].size() < DEPTH);
        end
        chk($sformatf("d%0d_ready", d), 64'(o_rdy[d]), 64'(er));
        chk($sformatf("d%0d_full", d), 64'(o_full[d]), 64'(ef));
        chk($sformatf("d%0d_valid", d), 64'(o_vld[d]), 64'(m_vld[d]));
        chk($sformatf("d%0d_count", d), 64'(o_cnt[d]), 64'(m_cnt[d]));
        if (!m_vld[d]) begin
          chk($sformatf("d%0d_hold_addr", d), 64'(o_adr[d]), 64'(m_out[d].a));
          chk($sformatf("d%0d_hold_payload", d), 64'(o_pay[d]), 64'(m_out[d].p));
          chk($sformatf("d%0d_hold_channel", d), 64'(o_ch[d]), 64'(m_out[d].ch));
        end
      end
      step(d);
    end
    if (!rst) live = 1;
  end

  always begin
    ent_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (live && o_vld[d]) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d%0d_beat unexpected beat actual_addr=%0h required=none", d, o_adr[d]);
        end else begin
          e = exp_q[d][0];
          chk($sformatf("d%0d_beat_channel", d), 64'(o_ch[d]), 64'(e.ch));
          chk($sformatf("d%0d_beat_addr", d), 64'(o_adr[d]), 64'(e.a));
          chk($sformatf("d%0d_beat_payload", d), 64'(o_pay[d]), 64'(e.p));
          if (mrdy[d]) begin
            void'(exp_q[d].pop_front());
            if (d == 1) seq1.push_back(int'(e.ch));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vld[d]  = '0;
      en[d]   = 3'b111;
      mrdy[d] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        adr[d][k] = '0;
        pay[d][k] = '0;
      end
    end

    // reset hold with ch0 requesting
    vld[0] = 3'b001;
    repeat (3) tick();
    chk("rst_ready", 64'(o_rdy[0]), 64'd0);
    chk("rst_valid", 64'(o_vld[0]), 64'd0);
    chk("rst_count", 64'(o_cnt[0]), 64'd0);
    vld[0] = '0;
    rst = 1'b1;
    #1;
    chk("release_ready2", 64'(o_rdy[0]), 64'h3);
    chk("release_ready3", 64'(o_rdy[1]), 64'h7);

    // single beat latency
    mrdy[0]   = 1'b1;
    adr[0][0] = 16'h0100;
    pay[0][0] = 32'h000000A5;
    vld[0]    = 3'b001;
    tick();
    vld[0] = '0;
    chk("single_not_yet", 64'(o_vld[0]), 64'd0);
    tick();
    chk("single_valid", 64'(o_vld[0]), 64'd1);
    chk("single_addr", 64'(o_adr[0]), 64'h100);
    chk("single_channel", 64'(o_ch[0]), 64'd0);
    chk("single_count0", 64'(o_cnt[0]), 64'd0);
    tick();
    chk("single_count1", 64'(o_cnt[0]), 64'd1);

    // back-pressure: six beats on ch1 against a stalled port
    mrdy[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adr[0][1] = 16'(i);
      pay[0][1] = $urandom;
      vld[0]    = 3'b010;
      tick();
    end
    chk("bp_full", 64'(o_full[0][1]), 64'd1);
    chk("bp_ready", 64'(o_rdy[0][1]), 64'd0);
    chk("bp_out_addr", 64'(o_adr[0]), 64'd0);
    chk("bp_out_channel", 64'(o_ch[0]), 64'd1);
    mrdy[0] = 1'b1;
    repeat (2) tick();
    vld[0] = '0;
    repeat (8) tick();

    // fixed priority with both channels streaming
    vld[0] = 3'b011;
    for (int i = 0; i < 10; i++) begin
      adr[0][0] = 16'(16'h0200 + i);
      adr[0][1] = 16'(16'h0300 + i);
      pay[0][0] = $urandom;
      pay[0][1] = $urandom;
      tick();
      if (i >= 1) chk("prio_ch0_only", 64'(o_ch[0]), 64'd0);
    end
    chk("prio_ch1_starved_full", 64'(o_full[0][1]), 64'd1);
    vld[0] = '0;
    repeat (8) tick();

    // round-robin over three pre-filled channels
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        adr[1][k] = 16'(16'h0400 + k * 16 + i);
        pay[1][k] = $urandom;
      end
      vld[1] = 3'b111;
      tick();
    end
    vld[1] = '0;
    repeat (2) tick();
    seq1.delete();
    mrdy[1] = 1'b1;
    repeat (8) tick();
    chk("rr_beats", 64'(seq1.size()), 64'd6);
    for (int j = 0; j < 6; j++) chk($sformatf("rr_seq%0d", j), 64'(seq1[j]), 64'(j % 3));

    // enable mask, then reset mid-operation
    en[0]   = 3'b010;
    mrdy[0] = 1'b1;
    vld[0]  = 3'b011;
    for (int i = 0; i < 5; i++) begin
      adr[0][0] = 16'(16'h0500 + i);
      adr[0][1] = 16'(16'h0600 + i);
      tick();
    end
    chk("mask_ch0_full", 64'(o_full[0][0]), 64'd1);
    chk("mask_ch1_out", 64'(o_ch[0]), 64'd1);
    rst = 1'b0;
    tick();
    chk("midrst_ready", 64'(o_rdy[0]), 64'd0);
    rst    = 1'b1;
    vld[0] = '0;
    en[0]  = 3'b111;
    #1;
    chk("midrst_full", 64'(o_full[0]), 64'd0);
    chk("midrst_valid", 64'(o_vld[0]), 64'd0);
    chk("midrst_count", 64'(o_cnt[0]), 64'd0);
    chk("midrst_ready_back", 64'(o_rdy[0]), 64'h3);
    repeat (3) tick();
    chk("midrst_no_stale", 64'(o_vld[0]), 64'd0);

    // randomized traffic on both arbiters
    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        vld[d]  = 3'($urandom);
        en[d]   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
        mrdy[d] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 3; k++) begin
          adr[d][k] = 16'($urandom);
          pay[d][k] = $urandom;
        end
      end
      rst = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d]  = '0;
      en[d]   = 3'b111;
      mrdy[d] = 1'b1;
    end
    repeat (20) tick();
    chk("drain_d0", 64'(exp_q[0].size()), 64'd0);
    chk("drain_d1", 64'(exp_q[1].size()), 64'd0);
    chk("drain_idle_d0", 64'(o_vld[0]), 64'd0);
    chk("drain_idle_d1", 64'(o_vld[1]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
